// File: rtl/tensor_core_matrix_loader.sv
// Streaming loader for the tensor core register file.
// Collects the 18 signed operand elements (two 3x3 matrices, row-major)
// from a valid/ready byte stream. Flat addresses 0-15 are written four at a
// time through the quad port. Addresses 16-17 go through the single-element
// port, and a done pulse ends the load. All outputs are registered.
module tensor_core_matrix_loader #(
  parameter int NUM_ELEMENTS = 18,
  parameter int BUS_WIDTH    = 7
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  input  logic                              start_in,
  input  logic                              s_valid_in,
  input  logic signed [BUS_WIDTH:0]         s_data_in,
  output logic                              s_ready_out,
  output logic                              quad_write_enable_out,
  output logic [2:0]                        quad_write_register_address_out,
  output logic signed [3:0][BUS_WIDTH:0]    quad_write_data_out,
  output logic                              non_bulk_write_enable_out,
  output logic [4:0]                        non_bulk_write_register_address_out,
  output logic signed [BUS_WIDTH:0]         non_bulk_write_data_out,
  output logic                              busy_out,
  output logic                              done_out
);

  // Quad groups cover every element except the last two, which the quad
  // port cannot address and which are written one at a time.
  localparam int          QUAD_GROUPS = (NUM_ELEMENTS - 2) / 4;
  localparam logic [2:0]  LAST_GROUP  = 3'(QUAD_GROUPS);
  localparam logic [4:0]  TAIL_A_ADDR = 5'(NUM_ELEMENTS - 2);
  localparam logic [4:0]  TAIL_B_ADDR = 5'(NUM_ELEMENTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    QUAD,
    TAIL_A,
    TAIL_B,
    DONE
  } state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      lane, lane_nxt;
  logic [2:0]                      group, group_nxt;
  logic signed [3:0][BUS_WIDTH:0]  pack, pack_nxt;

  logic                            ready_nxt;
  logic                            busy_nxt;
  logic                            done_nxt;
  logic                            quad_we_nxt;
  logic [2:0]                      quad_addr_nxt;
  logic signed [3:0][BUS_WIDTH:0]  quad_data_nxt;
  logic                            nb_we_nxt;
  logic [4:0]                      nb_addr_nxt;
  logic signed [BUS_WIDTH:0]       nb_data_nxt;

  // Next-state, packing and next-output decode. Outputs are derived from
  // the next state so that they are registered with the state itself.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    group_nxt = group;
    pack_nxt  = pack;

    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_nxt = COLLECT;
          lane_nxt  = '0;
          group_nxt = '0;
        end
      end
      COLLECT: begin
        // s_ready_out is high exactly when the state is COLLECT.
        if (s_valid_in) begin
          pack_nxt[lane] = s_data_in;
          lane_nxt       = lane + 2'd1;
          if (group == LAST_GROUP && lane == 2'd1) begin
            state_nxt = TAIL_A;
          end else if (lane == 2'd3) begin
            state_nxt = QUAD;
          end
        end
      end
      QUAD: begin
        group_nxt = group + 3'd1;
        lane_nxt  = '0;
        state_nxt = COLLECT;
      end
      TAIL_A:  state_nxt = TAIL_B;
      TAIL_B:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ready_nxt     = (state_nxt == COLLECT);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);

    // The group counter only advances on leaving QUAD, so it still holds
    // the index of the group being written.
    quad_we_nxt   = (state_nxt == QUAD);
    quad_addr_nxt = quad_we_nxt ? group : 3'd0;
    quad_data_nxt = quad_we_nxt ? pack_nxt : '0;

    nb_we_nxt     = (state_nxt == TAIL_A) || (state_nxt == TAIL_B);
    nb_addr_nxt   = 5'd0;
    nb_data_nxt   = '0;
    if (state_nxt == TAIL_A) begin
      nb_addr_nxt = TAIL_A_ADDR;
      nb_data_nxt = pack_nxt[0];
    end else if (state_nxt == TAIL_B) begin
      nb_addr_nxt = TAIL_B_ADDR;
      nb_data_nxt = pack_nxt[1];
    end
  end

  // State, counters, packing buffer and registered outputs. Reset abandons
  // any partial load and clears every output and the buffer.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state                               <= IDLE;
      lane                                <= '0;
      group                               <= '0;
      pack                                <= '0;
      s_ready_out                         <= 1'b0;
      busy_out                            <= 1'b0;
      done_out                            <= 1'b0;
      quad_write_enable_out               <= 1'b0;
      quad_write_register_address_out     <= '0;
      quad_write_data_out                 <= '0;
      non_bulk_write_enable_out           <= 1'b0;
      non_bulk_write_register_address_out <= '0;
      non_bulk_write_data_out             <= '0;
    end else begin
      state                               <= state_nxt;
      lane                                <= lane_nxt;
      group                               <= group_nxt;
      pack                                <= pack_nxt;
      s_ready_out                         <= ready_nxt;
      busy_out                            <= busy_nxt;
      done_out                            <= done_nxt;
      quad_write_enable_out               <= quad_we_nxt;
      quad_write_register_address_out     <= quad_addr_nxt;
      quad_write_data_out                 <= quad_data_nxt;
      non_bulk_write_enable_out           <= nb_we_nxt;
      non_bulk_write_register_address_out <= nb_addr_nxt;
      non_bulk_write_data_out             <= nb_data_nxt;
    end
  end

endmodule

// File: tb/tb_tensor_core_matrix_loader.sv
// Directed bench for tensor_core_matrix_loader: full loads with and without
// upstream gaps, ignored start pulses, asynchronous abort, idle traffic and
// back-to-back loads, checked against a register-file model and write log.
`timescale 1ns/1ps
module tb_tensor_core_matrix_loader;

  logic                    clock_in = 1'b0;
  logic                    reset_in;
  logic                    start_in;
  logic                    s_valid_in;
  logic signed [7:0]       s_data_in;
  logic                    s_ready_out;
  logic                    quad_write_enable_out;
  logic [2:0]              quad_write_register_address_out;
  logic signed [3:0][7:0]  quad_write_data_out;
  logic                    non_bulk_write_enable_out;
  logic [4:0]              non_bulk_write_register_address_out;
  logic signed [7:0]       non_bulk_write_data_out;
  logic                    busy_out;
  logic                    done_out;

  tensor_core_matrix_loader dut (
    .clock_in                            (clock_in),
    .reset_in                            (reset_in),
    .start_in                            (start_in),
    .s_valid_in                          (s_valid_in),
    .s_data_in                           (s_data_in),
    .s_ready_out                         (s_ready_out),
    .quad_write_enable_out               (quad_write_enable_out),
    .quad_write_register_address_out     (quad_write_register_address_out),
    .quad_write_data_out                 (quad_write_data_out),
    .non_bulk_write_enable_out           (non_bulk_write_enable_out),
    .non_bulk_write_register_address_out (non_bulk_write_register_address_out),
    .non_bulk_write_data_out             (non_bulk_write_data_out),
    .busy_out                            (busy_out),
    .done_out                            (done_out)
  );

  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected element stream for the current load.
  logic signed [7:0] stim [18];

  // Write log and register-file model, updated mid-cycle.
  int                ncyc = 0;
  logic signed [7:0] acc_d[$];
  int                acc_c[$];
  int                q_addr[$];
  logic [31:0]       q_data[$];
  int                q_cyc[$];
  int                nb_addr[$];
  logic signed [7:0] nb_data[$];
  int                nb_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                st_cyc   = 0;
  logic signed [7:0] mem [18];

  always @(negedge clock_in) begin
    ncyc++;
    if (start_in && !busy_out) st_cyc = ncyc;
    if (s_valid_in && s_ready_out) begin
      acc_d.push_back(s_data_in);
      acc_c.push_back(ncyc);
    end
    if (quad_write_enable_out || non_bulk_write_enable_out)
      chk("one_strobe", {31'd0, quad_write_enable_out & non_bulk_write_enable_out}, 32'd0);
    if (quad_write_enable_out) begin
      q_addr.push_back(int'(quad_write_register_address_out));
      q_data.push_back(quad_write_data_out);
      q_cyc.push_back(ncyc);
      for (int i = 0; i < 4; i++) begin
        if (int'(quad_write_register_address_out) * 4 + i < 18)
          mem[int'(quad_write_register_address_out) * 4 + i] = quad_write_data_out[i];
      end
    end
    if (non_bulk_write_enable_out) begin
      nb_addr.push_back(int'(non_bulk_write_register_address_out));
      nb_data.push_back(non_bulk_write_data_out);
      nb_cyc.push_back(ncyc);
      if (non_bulk_write_register_address_out < 5'd18)
        mem[non_bulk_write_register_address_out] = non_bulk_write_data_out;
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  task automatic clear_log();
    acc_d.delete(); acc_c.delete();
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    nb_addr.delete(); nb_data.delete(); nb_cyc.delete();
    done_cnt = 0;
    for (int k = 0; k < 18; k++) mem[k] = 8'sd0;
  endtask

  // All tasks below start and end at 1 ns after a rising edge.
  task automatic do_start();
    start_in = 1'b1;
    @(posedge clock_in); #1;
    start_in = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int count, input int poke);
    int  idx = 0;
    int  n   = 0;
    bit  v;
    logic rdy;
    while (idx < count && n < 3000) begin
      v          = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_valid_in = v;
      s_data_in  = stim[idx];
      start_in   = (poke >= 0 && idx == poke);
      @(negedge clock_in);
      rdy = s_ready_out;
      @(posedge clock_in); #1;
      if (v && rdy) idx++;
      n++;
    end
    s_valid_in = 1'b0;
    start_in   = 1'b0;
    chk("feed_count", idx, count);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_out && n < 200) begin
      @(posedge clock_in); #1;
      n++;
    end
    chk({tag, "/done_seen"}, {31'd0, done_out}, 32'd1);
  endtask

  task automatic check_load(input string tag, input bit timed);
    logic [31:0] e;
    chk({tag, "/acc_n"}, acc_d.size(), 18);
    if (acc_d.size() == 18)
      for (int k = 0; k < 18; k++) chk({tag, "/acc_data"}, acc_d[k], stim[k]);
    chk({tag, "/quad_n"}, q_addr.size(), 4);
    if (q_addr.size() == 4) begin
      for (int g = 0; g < 4; g++) begin
        e = {stim[4*g+3], stim[4*g+2], stim[4*g+1], stim[4*g]};
        chk({tag, "/quad_addr"}, q_addr[g], g);
        chk({tag, "/quad_data"}, q_data[g], e);
        if (acc_c.size() == 18) chk({tag, "/quad_lat"}, q_cyc[g], acc_c[4*g+3] + 1);
      end
    end
    chk({tag, "/nb_n"}, nb_addr.size(), 2);
    if (nb_addr.size() == 2) begin
      chk({tag, "/nb_addr0"}, nb_addr[0], 16);
      chk({tag, "/nb_data0"}, nb_data[0], stim[16]);
      chk({tag, "/nb_addr1"}, nb_addr[1], 17);
      chk({tag, "/nb_data1"}, nb_data[1], stim[17]);
      if (acc_c.size() == 18) begin
        chk({tag, "/nb_lat0"}, nb_cyc[0], acc_c[17] + 1);
        chk({tag, "/nb_lat1"}, nb_cyc[1], acc_c[17] + 2);
      end
    end
    chk({tag, "/done_n"}, done_cnt, 1);
    if (acc_c.size() == 18) chk({tag, "/done_lat"}, done_cyc, acc_c[17] + 3);
    if (timed) chk({tag, "/load_cycles"}, done_cyc - st_cyc + 1, 26);
    for (int k = 0; k < 18; k++) chk({tag, "/regfile"}, mem[k], stim[k]);
    chk({tag, "/busy_after"}, {31'd0, busy_out}, 32'd0);
    chk({tag, "/ready_after"}, {31'd0, s_ready_out}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/ready"}, {31'd0, s_ready_out}, 32'd0);
    chk({tag, "/busy"}, {31'd0, busy_out}, 32'd0);
    chk({tag, "/done"}, {31'd0, done_out}, 32'd0);
    chk({tag, "/quad_we"}, {31'd0, quad_write_enable_out}, 32'd0);
    chk({tag, "/quad_addr"}, {29'd0, quad_write_register_address_out}, 32'd0);
    chk({tag, "/quad_data"}, quad_write_data_out, 32'd0);
    chk({tag, "/nb_we"}, {31'd0, non_bulk_write_enable_out}, 32'd0);
    chk({tag, "/nb_addr"}, {27'd0, non_bulk_write_register_address_out}, 32'd0);
    chk({tag, "/nb_data"}, {24'd0, non_bulk_write_data_out}, 32'd0);
  endtask

  task automatic full_load(input string tag, input bit gaps, input bit timed);
    do_start();
    feed(gaps, 18, -1);
    wait_done(tag);
    @(posedge clock_in); #1;
    check_load(tag, timed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in   = 1'b1;
    start_in   = 1'b0;
    s_valid_in = 1'b0;
    s_data_in  = 8'sd0;
    for (int k = 0; k < 18; k++) mem[k] = 8'sd0;
    repeat (2) @(posedge clock_in);
    #1;
    chk_all_zero("reset");
    reset_in = 1'b0;
    @(posedge clock_in); #1;

    // Full load, valid held high, data 1..18.
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k + 1);
    full_load("full", 1'b0, 1'b1);

    // Random upstream gaps, data -128..-111.
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k - 128);
    full_load("gaps", 1'b1, 1'b0);

    // start pulsed during COLLECT and during TAIL_B is ignored.
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k + 30);
    do_start();
    feed(1'b0, 18, 5);
    @(posedge clock_in); #1;
    start_in = 1'b1;
    @(posedge clock_in); #1;
    start_in = 1'b0;
    wait_done("stray");
    @(posedge clock_in); #1;
    check_load("stray", 1'b1);
    repeat (4) @(posedge clock_in);
    #1;
    chk("stray/no_restart", {31'd0, busy_out}, 32'd0);
    chk("stray/single_done", done_cnt, 1);

    // Asynchronous reset mid-cycle after 7 accepted elements.
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k + 70);
    do_start();
    feed(1'b0, 7, -1);
    chk("abort/ready_before", {31'd0, s_ready_out}, 32'd1);
    #3;
    reset_in = 1'b1;
    #1;
    chk_all_zero("abort");
    chk("abort/acc_n", acc_d.size(), 7);
    @(negedge clock_in);
    reset_in = 1'b0;
    @(posedge clock_in); #1;
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k + 90);
    full_load("after_abort", 1'b0, 1'b1);

    // Valid traffic in IDLE without start is never consumed.
    clear_log();
    s_valid_in = 1'b1;
    s_data_in  = 8'sh55;
    repeat (8) @(posedge clock_in);
    #1;
    s_valid_in = 1'b0;
    chk("idle/acc_n", acc_d.size(), 0);
    chk("idle/quad_n", q_addr.size(), 0);
    chk("idle/nb_n", nb_addr.size(), 0);
    chk("idle/done_n", done_cnt, 0);
    chk("idle/ready", {31'd0, s_ready_out}, 32'd0);

    // Back-to-back loads: second start in the cycle right after done.
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k + 100);
    full_load("b2b_a", 1'b0, 1'b1);
    clear_log();
    for (int k = 0; k < 18; k++) stim[k] = 8'(k - 50);
    full_load("b2b_b", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
